pf_ram_arbiter: RTL and testbench

Sequencer and arbiter for the 1K x 8 asynchronous playfield RAM. It shares the RAM between the video tile fetcher (read-only, high priority) and the 6502 CPU bus (read/write). It generates the RAM's `cs_n`, `we_n`, address and write data with registered setup and hold around every strobe. A streak counter guarantees the CPU a slot under continuous video load.

---
 rtl/pf_ram_pkg.sv | 23 ++
 rtl/pf_ram_prio.sv | 50 +++++
 rtl/pf_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_pf_ram_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_ram_pkg.sv
// pf_ram_pkg
// Shared definitions for the playfield RAM arbiter slice.
//   state_t     : access sequencer states (IDLE, SETUP, STROBE, DONE)
//   REQ_VID     : requester id of the video tile fetcher
//   REQ_CPU     : requester id of the 6502 CPU bus
//   AW_DEFAULT  : default RAM address width (1K deep)
//   DW_DEFAULT  : default RAM data width
package pf_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic REQ_VID = 1'b0;
  localparam logic REQ_CPU = 1'b1;

  localparam int AW_DEFAULT = 10;
  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/pf_ram_prio.sv
// pf_ram_prio
// Grant logic for the playfield RAM. Video has priority, but the streak
// counter forces a CPU grant once VID_BURST video grants have been given
// back to back while the CPU was waiting.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   vid_req      : video read request (level)
//   cpu_req      : CPU request (level)
//   grant_en     : high while the sequencer is in IDLE and may grant
//   grant_vid    : video wins this IDLE cycle (combinational)
//   grant_cpu    : CPU wins this IDLE cycle (combinational)
module pf_ram_prio
  import pf_ram_pkg::*;
#(
  parameter int VID_BURST = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vid_req,
  input  logic cpu_req,
  input  logic grant_en,
  output logic grant_vid,
  output logic grant_cpu
);

  localparam logic [3:0] BURST_LIMIT = 4'(VID_BURST);

  logic [3:0] r_streak;
  logic       w_cpu_turn;

  // The CPU only takes precedence once video has used up its burst.
  assign w_cpu_turn = cpu_req && (r_streak == BURST_LIMIT);
  assign grant_vid  = grant_en && vid_req && !w_cpu_turn;
  assign grant_cpu  = grant_en && cpu_req && !grant_vid;

  // A video grant only reaches the increment branch while cpu_req is
  // high, because an IDLE cycle with cpu_req low clears the streak first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= 4'd0;
    end else if (grant_cpu) begin
      r_streak <= 4'd0;
    end else if (grant_en && !cpu_req) begin
      r_streak <= 4'd0;
    end else if (grant_vid && (r_streak != BURST_LIMIT)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

endmodule

// File: rtl/pf_ram_arbiter.sv
// pf_ram_arbiter
// Sequencer for the 1K x 8 asynchronous playfield RAM, shared between the
// video tile fetcher (read only) and the 6502 CPU bus (read/write). Each
// access is IDLE (grant) -> SETUP -> STROBE -> DONE, so address and write
// data are stable one cycle before and after the write strobe.
// Ports:
//   clk, reset_n                 : system clock, asynchronous active-low reset
//   vid_req/vid_addr             : video read request and address
//   vid_ack/vid_rdata            : video ack pulse and held read data
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request, direction, address, data
//   cpu_ack/cpu_rdata            : CPU ack pulse and held read data
//   ram_a/ram_din/ram_dout       : RAM address, write data, read data
//   ram_cs_n/ram_we_n            : RAM chip select and write enable (active low)
//   busy                         : high whenever the sequencer is not IDLE
module pf_ram_arbiter
  import pf_ram_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int VID_BURST = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_cs_n,
  output logic          ram_we_n,
  output logic          busy
);

  state_t        r_state;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_ram_a;
  logic [DW-1:0] r_ram_din;
  logic          r_cs_n;
  logic          r_we_n;
  logic          r_vid_ack;
  logic          r_cpu_ack;
  logic [DW-1:0] r_vid_rdata;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_busy;

  logic          w_grant_en;
  logic          w_grant_vid;
  logic          w_grant_cpu;

  assign w_grant_en = (r_state == ST_IDLE);

  pf_ram_prio #(
    .VID_BURST (VID_BURST)
  ) u_prio (
    .clk       (clk),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .cpu_req   (cpu_req),
    .grant_en  (w_grant_en),
    .grant_vid (w_grant_vid),
    .grant_cpu (w_grant_cpu)
  );

  // Every output is set on the edge that enters the state it belongs to,
  // so the RAM pins are glitch-free registers. The RAM address/data
  // registers double as the latched request, which is why later changes
  // on cpu_addr/cpu_wdata have no effect on the access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= REQ_VID;
      r_we        <= 1'b0;
      r_ram_a     <= '0;
      r_ram_din   <= '0;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_rdata <= '0;
      r_cpu_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vid) begin
            r_owner <= REQ_VID;
            r_we    <= 1'b0;
            r_ram_a <= vid_addr;
            r_cs_n  <= 1'b0;
            r_we_n  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end else if (w_grant_cpu) begin
            r_owner   <= REQ_CPU;
            r_we      <= cpu_we;
            r_ram_a   <= cpu_addr;
            r_ram_din <= cpu_wdata;
            r_cs_n    <= 1'b0;
            r_we_n    <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Video is never a write, so only a CPU write lowers we_n.
          r_we_n  <= !(r_we && (r_owner == REQ_CPU));
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          r_cs_n <= 1'b1;
          r_we_n <= 1'b1;
          if (r_owner == REQ_VID) begin
            r_vid_rdata <= ram_dout;
            r_vid_ack   <= 1'b1;
          end else begin
            if (!r_we) begin
              r_cpu_rdata <= ram_dout;
            end
            r_cpu_ack <= 1'b1;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cs_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vid_ack   = r_vid_ack;
  assign vid_rdata = r_vid_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign ram_a     = r_ram_a;
  assign ram_din   = r_ram_din;
  assign ram_cs_n  = r_cs_n;
  assign ram_we_n  = r_we_n;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pf_ram_arbiter.sv
// tb_pf_ram_arbiter
// Directed bench for pf_ram_arbiter with a behavioural 1K x 8 RAM that
// commits a write on the clock edge ending a cycle with cs_n and we_n low.
// RAM contents start as addr[7:0] ^ 8'hA5.
module tb_pf_ram_arbiter;

  logic       clk;
  logic       reset_n;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic       vid_ack;
  logic [7:0] vid_rdata;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [9:0] ram_a;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       ram_cs_n;
  logic       ram_we_n;
  logic       busy;

  int errors;
  int checks;

  logic [7:0] mem [0:1023];
  logic       memLoad;

  pf_ram_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_rdata (vid_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ram_a     (ram_a),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_cs_n  (ram_cs_n),
    .ram_we_n  (ram_we_n),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preload while memLoad is high, otherwise commit writes.
  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= 8'(i) ^ 8'hA5;
      end
    end else if (!ram_cs_n && !ram_we_n) begin
      mem[ram_a] <= ram_din;
    end
  end

  assign ram_dout = mem[ram_a];

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vReq, input logic [9:0] vAddr,
                               input logic cReq, input logic cWe,
                               input logic [9:0] cAddr, input logic [7:0] cData);
    vid_req   = vReq;
    vid_addr  = vAddr;
    cpu_req   = cReq;
    cpu_we    = cWe;
    cpu_addr  = cAddr;
    cpu_wdata = cData;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int vidAcks;
    int cpuWait;
    int resumeAt;
    int extraAcks;
    int busyCycles;

    errors  = 0;
    checks  = 0;
    memLoad = 1'b1;
    reset_n = 1'b0;
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);

    // ---------------- reset state
    step(); step(); step();
    memLoad = 1'b0;
    checkOutput("rst_cs_n", ram_cs_n, 1);
    checkOutput("rst_we_n", ram_we_n, 1);
    checkOutput("rst_ram_a", ram_a, 0);
    checkOutput("rst_ram_din", ram_din, 0);
    checkOutput("rst_acks", {vid_ack, cpu_ack}, 0);
    checkOutput("rst_rdata", {vid_rdata, cpu_rdata}, 0);
    checkOutput("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    // ---------------- single CPU write of 0x5A to 0x3FF, then read back
    $display("[TB] CPU write then read");
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 8'h5A);
    step();
    checkOutput("wr_setup_pins", {busy, ram_cs_n, ram_we_n}, 3'b101);
    checkOutput("wr_setup_a", ram_a, 10'h3FF);
    checkOutput("wr_setup_din", ram_din, 8'h5A);
    step();
    checkOutput("wr_strobe_pins", {ram_cs_n, ram_we_n}, 2'b00);
    checkOutput("wr_strobe_ack", cpu_ack, 0);
    step();
    checkOutput("wr_done_pins", {cpu_ack, ram_cs_n, ram_we_n}, 3'b111);
    checkOutput("wr_done_a", ram_a, 10'h3FF);
    checkOutput("wr_done_din", ram_din, 8'h5A);
    cpu_req = 1'b0;
    step();
    checkOutput("wr_idle", {busy, cpu_ack}, 2'b00);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 8'h00);
    step();
    step();
    checkOutput("rd_strobe_we_n", ram_we_n, 1);
    step();
    checkOutput("rd_ack", cpu_ack, 1);
    checkOutput("rd_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    step();

    // ---------------- simultaneous first request: video first, CPU +4
    $display("[TB] simultaneous requests");
    applyStimulus(1'b1, 10'h020, 1'b1, 1'b1, 10'h3FE, 8'h77);
    step();
    checkOutput("sim_vid_setup_a", ram_a, 10'h020);
    step();
    checkOutput("sim_vid_no_write", {ram_cs_n, ram_we_n}, 2'b01);
    step();
    checkOutput("sim_vid_ack", {vid_ack, cpu_ack}, 2'b10);
    checkOutput("sim_vid_rdata", vid_rdata, 8'h85);
    vid_req = 1'b0;
    step();
    checkOutput("sim_gap", {vid_ack, cpu_ack, busy}, 3'b000);
    step();
    checkOutput("sim_cpu_setup_a", ram_a, 10'h3FE);
    step();
    checkOutput("sim_cpu_write", {ram_cs_n, ram_we_n}, 2'b00);
    step();
    checkOutput("sim_cpu_ack", {vid_ack, cpu_ack}, 2'b01);
    checkOutput("sim_cpu_rdata_held", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    step();

    // ---------------- starvation bound with VID_BURST = 4
    $display("[TB] starvation bound");
    applyStimulus(1'b1, 10'h021, 1'b1, 1'b0, 10'h3FE, 8'h00);
    vidAcks = 0;
    cpuWait = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (cpu_ack) begin
        cpuWait = c;
        break;
      end
      if (vid_ack) vidAcks++;
    end
    checkOutput("starve_vid_acks", vidAcks, 4);
    checkOutput("starve_cpu_wait", cpuWait, 19);
    checkOutput("starve_wait_bound", (cpuWait > 0) && (cpuWait <= 20), 1);
    checkOutput("starve_cpu_rdata", cpu_rdata, 8'h77);
    cpu_req = 1'b0;
    resumeAt = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (vid_ack) begin
        resumeAt = c;
        break;
      end
    end
    checkOutput("starve_vid_resume", resumeAt, 4);
    checkOutput("starve_vid_rdata", vid_rdata, 8'h84);
    vid_req = 1'b0;
    step();

    // ---------------- address/data change after the grant is ignored
    $display("[TB] late address change");
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h155, 8'hAA);
    step();
    cpu_addr  = 10'h2AA;
    cpu_wdata = 8'h55;
    step();
    checkOutput("late_strobe_a", ram_a, 10'h155);
    checkOutput("late_strobe_din", ram_din, 8'hAA);
    step();
    checkOutput("late_done_a", ram_a, 10'h155);
    checkOutput("late_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    step();

    // ---------------- reset during the strobe of a write of 0xFF to 0x010
    $display("[TB] reset mid-write");
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 8'hFF);
    step();
    step();
    checkOutput("rmw_strobe_we_n", ram_we_n, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rmw_pins", {ram_cs_n, ram_we_n, busy, cpu_ack}, 4'b1100);
    checkOutput("rmw_ram_a", ram_a, 0);
    cpu_req = 1'b0;
    step();
    step();
    checkOutput("rmw_no_ack", cpu_ack, 0);
    reset_n = 1'b1;
    step();
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h010, 8'h00);
    step();
    step();
    step();
    checkOutput("rmw_read_ack", cpu_ack, 1);
    checkOutput("rmw_read_data", cpu_rdata, 8'hB5);
    cpu_req = 1'b0;
    step();

    // ---------------- request dropped during SETUP still completes once
    $display("[TB] dropped request");
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h155, 8'h00);
    step();
    cpu_req = 1'b0;
    step();
    step();
    checkOutput("drop_ack", cpu_ack, 1);
    checkOutput("drop_rdata", cpu_rdata, 8'hAA);
    extraAcks  = 0;
    busyCycles = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (cpu_ack || vid_ack) extraAcks++;
      if (busy) busyCycles++;
    end
    checkOutput("drop_no_more_acks", extraAcks, 0);
    checkOutput("drop_stays_idle", busyCycles, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
